fwrisc_prefetch: RTL

// Parametrised instruction prefetch unit for the fwrisc core. It replaces the single-instruction

---
 rtl/fwrisc_prefetch.sv | 101 ++++++++++
 1 files changed

// File: rtl/fwrisc_prefetch.sv
// Instruction prefetch queue for fwrisc: sequential word fetches into a DEPTH-entry {pc, instr} FIFO.
// Optional performance counters are built when FWRISC_PREFETCH_PERF_EN is defined.
`timescale 1ns/1ps
module fwrisc_prefetch #(
  parameter int          DEPTH     = 4,
  parameter logic [31:0] RESET_VEC = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  output logic [31:0] iaddr,
  output logic        ivalid,
  input  logic [31:0] idata,
  input  logic        iready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  output logic [31:0] perf_fetch,
  output logic [31:0] perf_flushed
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW-1:0] PTR_ONE = 1;
  localparam logic [PW:0]   CNT_ONE = 1;
  localparam logic [PW:0]   CNT_FULL = (PW+1)'(DEPTH);

  logic [31:0]   pc_q    [DEPTH];
  logic [31:0]   instr_q [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [PW:0]   count;
  logic [31:0]   fetch_pc;
  logic          push;
  logic          pop;
  logic          unused_flush_lsb;

  assign unused_flush_lsb = ^flush_pc[1:0];

  assign ivalid      = !reset && !flush && (count < CNT_FULL);
  assign iaddr       = fetch_pc;
  assign instr_valid = !reset && (count != '0);
  assign instr       = instr_q[rd_ptr];
  assign instr_pc    = pc_q[rd_ptr];

  // A flush cancels any pop presented in the same cycle.
  assign push = ivalid && iready;
  assign pop  = instr_valid && instr_ready && !flush;

  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_pc <= {RESET_VEC[31:2], 2'b00};
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else if (flush) begin
      fetch_pc <= {flush_pc[31:2], 2'b00};
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else begin
      if (push) begin
        pc_q[wr_ptr]    <= fetch_pc;
        instr_q[wr_ptr] <= idata;
        wr_ptr          <= wr_ptr + PTR_ONE;
        fetch_pc        <= fetch_pc + 32'd4;
      end
      if (pop)
        rd_ptr <= rd_ptr + PTR_ONE;
      if (push && !pop)
        count <= count + CNT_ONE;
      else if (pop && !push)
        count <= count - CNT_ONE;
    end
  end

`ifdef FWRISC_PREFETCH_PERF_EN
  logic [31:0] perf_fetch_q;
  logic [31:0] perf_flushed_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      perf_fetch_q   <= '0;
      perf_flushed_q <= '0;
    end else begin
      if (push)
        perf_fetch_q <= perf_fetch_q + 32'd1;
      if (flush)
        perf_flushed_q <= perf_flushed_q + 32'(count);
    end
  end

  assign perf_fetch   = perf_fetch_q;
  assign perf_flushed = perf_flushed_q;
`else
  assign perf_fetch   = 32'd0;
  assign perf_flushed = 32'd0;
`endif

endmodule
